// File: rtl/tytra_map_pkg.sv
// Shared definitions for TyTra map nodes: operation codes and a width helper.
package tytra_map_pkg;

    localparam int OP_PASS  = 0;
    localparam int OP_ADD   = 1;
    localparam int OP_SUB   = 2;
    localparam int OP_MUL   = 3;
    localparam int OP_CONST = 4;

    // Ceiling log2, usable in constant expressions; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tytra_sync_fifo.sv
// Show-ahead synchronous FIFO; the head word is presented whenever it is not
// empty, and any non-power-of-2 depth is handled by explicit pointer wrap.
module tytra_sync_fifo
    import tytra_map_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         rd,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);

    localparam int PTRW = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CNTW = clog2(DEPTH + 1);

    logic [W-1:0]    mem [DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [CNTW-1:0] count;
    logic            do_rd;
    logic            do_wr;

    assign empty = (count == '0);
    assign full  = (count == CNTW'(DEPTH));
    assign do_rd = rd & ~empty;
    assign do_wr = wr & (~full | do_rd);
    assign rdata = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous write and read keeps the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= (wr_ptr == PTRW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == PTRW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wdata;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(wr && full && !rd));

endmodule

// File: rtl/tytra_map_node_pipe.sv
// Leaf map node: joins NIN streams, applies one element-wise op, delays the
// result LAT cycles and buffers it in a credit-managed output FIFO.
module tytra_map_node_pipe
    import tytra_map_pkg::*;
#(
    parameter int                 STREAMW = 32,
    parameter int                 NIN     = 2,
    parameter int                 LAT     = 3,
    parameter int                 OP      = OP_ADD,
    parameter logic [STREAMW-1:0] CONSTV  = '0,
    parameter int                 DEPTH   = LAT + 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NIN*STREAMW-1:0] in_data,
    input  logic [NIN-1:0]         ivalid,
    output logic                   iready,
    output logic [STREAMW-1:0]     out_data,
    output logic                   ovalid,
    input  logic                   oready
);

    localparam int OCCW = clog2(DEPTH + 1);

    if (NIN < 1 || NIN > 4) begin : g_bad_nin
        $error("tytra_map_node_pipe: NIN must be in 1..4");
    end
    if (LAT < 1) begin : g_bad_lat
        $error("tytra_map_node_pipe: LAT must be at least 1");
    end
    if (NIN == 1 && (OP == OP_SUB || OP == OP_MUL)) begin : g_bad_op
        $error("tytra_map_node_pipe: SUB and MUL need at least two inputs");
    end

    logic [STREAMW-1:0] operand [4];
    logic [STREAMW-1:0] result;
    logic [STREAMW-1:0] pipe_data [LAT];
    logic [LAT-1:0]     vpipe;
    logic [OCCW-1:0]    occ;
    logic               accept;
    logic               pop;
    logic               fifo_empty;
    logic               fifo_full;

    // Unused operand slots read as zero so the op mux never selects past NIN.
    for (genvar g = 0; g < 4; g++) begin : g_operand
        if (g < NIN) begin : g_used
            assign operand[g] = in_data[g*STREAMW +: STREAMW];
        end else begin : g_unused
            assign operand[g] = '0;
        end
    end

    // iready looks only at registered occupancy, so oready never reaches it.
    assign iready = (occ < OCCW'(DEPTH)) & ~rst;
    assign accept = (&ivalid) & iready;
    assign ovalid = ~fifo_empty;
    assign pop    = ovalid & oready;

    // Element-wise operation; all arithmetic wraps modulo 2^STREAMW.
    always_comb begin
        result = '0;
        case (OP)
            OP_PASS: result = operand[0];
            OP_ADD: begin
                for (int i = 0; i < NIN; i++) begin
                    result = result + operand[i];
                end
            end
            OP_SUB:   result = operand[0] - operand[1];
            OP_MUL:   result = operand[0] * operand[1];
            OP_CONST: result = CONSTV;
            default:  result = '0;
        endcase
    end

    // Non-stalling latency pipeline; the last valid bit writes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            vpipe[0] <= accept;
            if (accept) begin
                pipe_data[0] <= result;
            end
            for (int i = 1; i < LAT; i++) begin
                vpipe[i]     <= vpipe[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    // Credit counter: beats in flight plus beats buffered never exceed DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    tytra_sync_fifo #(
        .W     (STREAMW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (vpipe[LAT-1]),
        .wdata (pipe_data[LAT-1]),
        .rd    (pop),
        .rdata (out_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    a_occ_bound:   assert property (@(posedge clk) disable iff (rst) occ <= OCCW'(DEPTH));
    a_write_space: assert property (@(posedge clk) disable iff (rst) !(vpipe[LAT-1] && fifo_full));

endmodule

// File: tb/tb_tytra_map_node_pipe.sv
// Directed bench for tytra_map_node_pipe: reset, join, latency, back-pressure,
// wrap-around arithmetic for each op, and mid-operation reset.
module tb_tytra_map_node_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] in_data = '0;
    logic [1:0]  ivalid = '0;
    logic        oready = 1'b1;

    logic        iready, ovalid;
    logic [31:0] out_data;
    logic        iready_sub, ovalid_sub;
    logic [31:0] out_data_sub;
    logic        iready_mul, ovalid_mul;
    logic [31:0] out_data_mul;
    logic        iready_const, ovalid_const;
    logic [31:0] out_data_const;

    int          vectors = 0;
    int          miscompares = 0;
    int          seen;
    int          acc;
    int          nxt;
    int          pushed;
    int          popped;
    int          cycles;
    logic [31:0] last;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] got [$];
    logic [31:0] sb [$];

    tytra_map_node_pipe #(.STREAMW(32), .NIN(2), .LAT(3), .OP(1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .ivalid(ivalid), .iready(iready),
        .out_data(out_data), .ovalid(ovalid), .oready(oready));

    tytra_map_node_pipe #(.STREAMW(32), .NIN(2), .LAT(3), .OP(2)) dut_sub (
        .clk(clk), .rst(rst), .in_data(in_data), .ivalid(ivalid), .iready(iready_sub),
        .out_data(out_data_sub), .ovalid(ovalid_sub), .oready(oready));

    tytra_map_node_pipe #(.STREAMW(32), .NIN(2), .LAT(3), .OP(3)) dut_mul (
        .clk(clk), .rst(rst), .in_data(in_data), .ivalid(ivalid), .iready(iready_mul),
        .out_data(out_data_mul), .ovalid(ovalid_mul), .oready(oready));

    tytra_map_node_pipe #(.STREAMW(32), .NIN(2), .LAT(3), .OP(4), .CONSTV(32'h0000ABCD)) dut_const (
        .clk(clk), .rst(rst), .in_data(in_data), .ivalid(ivalid), .iready(iready_const),
        .out_data(out_data_const), .ovalid(ovalid_const), .oready(oready));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [31:0] in0, input logic [31:0] in1);
        ivalid  = v;
        in_data = {in1, in0};
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One beat accepted at the next edge, then wait until it reaches the FIFO head.
    task automatic sendBeat(input logic [31:0] in0, input logic [31:0] in1);
        applyStimulus(2'b11, in0, in1);
        tick();
        applyStimulus(2'b00, 32'd0, 32'd0);
        tick();
        tick();
        tick();
    endtask

    initial begin
        $display("[TB] reset");
        rst    = 1'b1;
        oready = 1'b1;
        applyStimulus(2'b11, 32'd9, 32'd9);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst_ovalid", ovalid, 32'd0);
            checkOutput("rst_out_data", out_data, 32'd0);
            checkOutput("rst_iready", iready, 32'd0);
        end
        rst = 1'b0;
        applyStimulus(2'b00, 32'd0, 32'd0);
        #1;
        checkOutput("release_iready", iready, 32'd1);

        $display("[TB] single ADD beat latency");
        applyStimulus(2'b11, 32'd5, 32'd7);
        tick();
        applyStimulus(2'b00, 32'd0, 32'd0);
        tick();
        checkOutput("add_k1_ovalid", ovalid, 32'd0);
        tick();
        checkOutput("add_k2_ovalid", ovalid, 32'd0);
        tick();
        checkOutput("add_k3_ovalid", ovalid, 32'd1);
        checkOutput("add_k3_data", out_data, 32'd12);
        tick();
        checkOutput("add_k4_ovalid", ovalid, 32'd0);

        $display("[TB] join with partial valids");
        seen = 0;
        last = '0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b01, 32'd100, 32'd200);
            tick();
            if (ovalid) begin seen++; last = out_data; end
        end
        applyStimulus(2'b11, 32'd1, 32'd2);
        tick();
        if (ovalid) begin seen++; last = out_data; end
        applyStimulus(2'b00, 32'd0, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ovalid) begin seen++; last = out_data; end
        end
        checkOutput("join_count", seen, 32'd1);
        checkOutput("join_data", last, 32'd3);

        $display("[TB] back-pressure");
        oready = 1'b0;
        acc    = 0;
        nxt    = 1;
        for (int c = 0; c < 12; c++) begin
            if (nxt <= 10) applyStimulus(2'b11, nxt, 32'd0);
            else           applyStimulus(2'b00, 32'd0, 32'd0);
            if (ivalid == 2'b11 && iready) begin acc++; nxt++; end
            tick();
        end
        checkOutput("bp_accepted", acc, 32'd5);
        checkOutput("bp_iready", iready, 32'd0);
        checkOutput("bp_ovalid", ovalid, 32'd1);
        checkOutput("bp_head", out_data, 32'd1);
        oready = 1'b1;
        for (int c = 0; c < 40 && got.size() < 10; c++) begin
            if (nxt <= 10) applyStimulus(2'b11, nxt, 32'd0);
            else           applyStimulus(2'b00, 32'd0, 32'd0);
            if (ovalid && oready) got.push_back(out_data);
            if (ivalid == 2'b11 && iready) nxt++;
            tick();
        end
        applyStimulus(2'b00, 32'd0, 32'd0);
        checkOutput("bp_out_count", got.size(), 32'd10);
        for (int i = 0; i < got.size(); i++) begin
            checkOutput("bp_order", got[i], i + 1);
        end

        $display("[TB] random back-pressure");
        pushed = 0;
        popped = 0;
        cycles = 0;
        while (popped < 1000 && cycles < 20000) begin
            oready = 1'($urandom_range(0, 1));
            a = 32'd0;
            b = 32'd0;
            if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
                a = $urandom;
                b = $urandom;
                applyStimulus(2'b11, a, b);
            end else begin
                applyStimulus(2'b00, 32'd0, 32'd0);
            end
            if (ovalid && oready) begin
                if (sb.size() == 0) checkOutput("rand_spurious", ovalid, 32'd0);
                else begin
                    checkOutput("rand_data", out_data, sb.pop_front());
                    popped++;
                end
            end
            if (ivalid == 2'b11 && iready) begin
                sb.push_back(a + b);
                pushed++;
            end
            cycles++;
            tick();
        end
        checkOutput("rand_popped", popped, 32'd1000);
        oready = 1'b1;
        applyStimulus(2'b00, 32'd0, 32'd0);
        tick();
        tick();

        $display("[TB] wrap-around arithmetic");
        sendBeat(32'hFFFFFFFF, 32'd2);
        checkOutput("wrap_add_ovalid", ovalid, 32'd1);
        checkOutput("wrap_add", out_data, 32'h00000001);
        checkOutput("wrap_sub_a", out_data_sub, 32'hFFFFFFFD);
        checkOutput("wrap_mul_a", out_data_mul, 32'hFFFFFFFE);
        checkOutput("const_ovalid", ovalid_const, 32'd1);
        checkOutput("const_a", out_data_const, 32'h0000ABCD);
        tick();
        sendBeat(32'd0, 32'd1);
        checkOutput("wrap_sub", out_data_sub, 32'hFFFFFFFF);
        checkOutput("add_b", out_data, 32'h00000001);
        tick();
        sendBeat(32'h00010000, 32'h00010000);
        checkOutput("wrap_mul_ovalid", ovalid_mul, 32'd1);
        checkOutput("wrap_mul", out_data_mul, 32'h00000000);
        checkOutput("add_c", out_data, 32'h00020000);
        checkOutput("const_c", out_data_const, 32'h0000ABCD);
        tick();

        $display("[TB] mid-operation reset");
        oready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b11, 32'd21 + i, 32'd0);
            tick();
        end
        applyStimulus(2'b00, 32'd0, 32'd0);
        checkOutput("mid_iready", iready, 32'd0);
        checkOutput("mid_ovalid", ovalid, 32'd1);
        checkOutput("mid_head", out_data, 32'd21);
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_ovalid", ovalid, 32'd0);
        checkOutput("mid_rst_out_data", out_data, 32'd0);
        checkOutput("mid_rst_iready", iready, 32'd0);
        rst    = 1'b0;
        oready = 1'b1;
        #1;
        checkOutput("mid_release_iready", iready, 32'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ovalid) seen++;
        end
        checkOutput("mid_no_stale", seen, 32'd0);
        sendBeat(32'd40, 32'd2);
        checkOutput("mid_new_ovalid", ovalid, 32'd1);
        checkOutput("mid_new_data", out_data, 32'd42);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
